// File: rtl/sd4_pp_gen_seq.sv
`default_nettype none
// ============================================================================
// Module   : sd4_pp_gen_seq
// Purpose  : Iterative radix-4 signed-digit (Booth) multiplier for nine lanes,
//            one SD4 digit per clock, results held on aligned_pp_0..8.
// Revision : 1.0 - initial release
// ============================================================================
module sd4_pp_gen_seq #(
  parameter int DATA_W   = 8,
  parameter int PP_W     = 16,
  parameter int N_DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [9*DATA_W-1:0] act_vec,
  input  logic [9*DATA_W-1:0] wgt_vec,
  output logic [PP_W-1:0]   aligned_pp_0,
  output logic [PP_W-1:0]   aligned_pp_1,
  output logic [PP_W-1:0]   aligned_pp_2,
  output logic [PP_W-1:0]   aligned_pp_3,
  output logic [PP_W-1:0]   aligned_pp_4,
  output logic [PP_W-1:0]   aligned_pp_5,
  output logic [PP_W-1:0]   aligned_pp_6,
  output logic [PP_W-1:0]   aligned_pp_7,
  output logic [PP_W-1:0]   aligned_pp_8,
  output logic              out_valid,
  busy
);

  localparam int         c_LANES    = 9;
  localparam logic [1:0] c_LAST_DIG = 2'(N_DIGITS - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [1:0]        r_cnt;
  logic              w_accept;
  logic              w_last;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_act [c_LANES];
  logic [DATA_W-1:0] r_wgt [c_LANES];
  logic [PP_W-1:0]   r_acc [c_LANES];
  logic [PP_W-1:0]   r_pp  [c_LANES];
  logic [PP_W-1:0]   w_sum [c_LANES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_next;
      if (w_accept)
        r_cnt <= 2'd0;
      else if (r_state == ST_RUN)
        r_cnt <= r_cnt + 2'd1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == c_LAST_DIG) begin
          w_last       = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_RUN);
  assign out_valid = r_out_valid;

  // Per-lane digit recode and shifted partial product for the current digit.
  for (genvar k = 0; k < c_LANES; k++) begin : g_lane
    logic [DATA_W:0] w_wext;
    logic [2:0]      w_trip;
    logic [PP_W-1:0] w_a;
    logic [PP_W-1:0] w_mag;
    logic [PP_W-1:0] w_pp;

    always_comb begin
      w_wext = {r_wgt[k], 1'b0};
      w_trip = 3'(w_wext >> {r_cnt, 1'b0});
      w_a    = {{(PP_W-DATA_W){r_act[k][DATA_W-1]}}, r_act[k]};
      case (w_trip)
        3'b001, 3'b010: w_mag = w_a;
        3'b011:         w_mag = w_a << 1;
        3'b100:         w_mag = -(w_a << 1);
        3'b101, 3'b110: w_mag = -w_a;
        default:        w_mag = '0;
      endcase
      w_pp = w_mag << {r_cnt, 1'b0};
    end

    assign w_sum[k] = r_acc[k] + w_pp;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      for (int k = 0; k < c_LANES; k++) begin
        r_act[k] <= '0;
        r_wgt[k] <= '0;
        r_acc[k] <= '0;
        r_pp[k]  <= '0;
      end
    end else begin
      r_out_valid <= w_last;
      for (int k = 0; k < c_LANES; k++) begin
        if (w_accept) begin
          r_act[k] <= act_vec[k*DATA_W +: DATA_W];
          r_wgt[k] <= wgt_vec[k*DATA_W +: DATA_W];
          r_acc[k] <= '0;
        end else if (r_state == ST_RUN) begin
          r_acc[k] <= w_sum[k];
        end
        // Results only move on completion so downstream sees them held.
        if (w_last)
          r_pp[k] <= w_sum[k];
      end
    end
  end

  assign aligned_pp_0 = r_pp[0];
  assign aligned_pp_1 = r_pp[1];
  assign aligned_pp_2 = r_pp[2];
  assign aligned_pp_3 = r_pp[3];
  assign aligned_pp_4 = r_pp[4];
  assign aligned_pp_5 = r_pp[5];
  assign aligned_pp_6 = r_pp[6];
  assign aligned_pp_7 = r_pp[7];
  assign aligned_pp_8 = r_pp[8];

endmodule
`default_nettype wire

// File: tb/tb_sd4_pp_gen_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd4_pp_gen_seq
// Purpose  : Scoreboard bench for sd4_pp_gen_seq against signed-multiply model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd4_pp_gen_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [71:0] act_vec = '0;
  logic [71:0] wgt_vec = '0;
  logic [15:0] pp [9];
  logic        out_valid;
  logic        busy;

  sd4_pp_gen_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .act_vec(act_vec), .wgt_vec(wgt_vec),
    .aligned_pp_0(pp[0]), .aligned_pp_1(pp[1]), .aligned_pp_2(pp[2]),
    .aligned_pp_3(pp[3]), .aligned_pp_4(pp[4]), .aligned_pp_5(pp[5]),
    .aligned_pp_6(pp[6]), .aligned_pp_7(pp[7]), .aligned_pp_8(pp[8]),
    .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p [9];
    int cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_acc    = 0;
  int   last_acc = 0;
  int   last_val [9];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Accept observer: reference products pushed at the edge the set is taken.
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      q.delete();
    end else if (in_valid && in_ready) begin
      exp_t e;
      for (int k = 0; k < 9; k++)
        e.p[k] = $signed(act_vec[8*k +: 8]) * $signed(wgt_vec[8*k +: 8]);
      e.cyc = cyc;
      q.push_back(e);
      n_acc++;
      last_acc = cyc;
    end
  end

  // Monitor: compare on out_valid, otherwise outputs must hold.
  initial for (int k = 0; k < 9; k++) last_val[k] = 0;
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 9; k++) last_val[k] = 0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("latency", cyc - e.cyc, 4);
        for (int k = 0; k < 9; k++) begin
          chk($sformatf("lane%0d", k), longint'($signed(pp[k])), e.p[k]);
          last_val[k] = e.p[k];
        end
      end
    end else begin
      for (int k = 0; k < 9; k++)
        chk($sformatf("hold%0d", k), longint'($signed(pp[k])), last_val[k]);
    end
  end

  task automatic send(input logic [71:0] a, input logic [71:0] w);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    act_vec  = a;
    wgt_vec  = w;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_empty", q.size(), 0);
  endtask

  function automatic logic [71:0] pack(input int v [9]);
    logic [71:0] r;
    for (int k = 0; k < 9; k++) r[8*k +: 8] = 8'(v[k]);
    return r;
  endfunction

  initial begin
    int a [9];
    int w [9];
    int acc0;
    int first_acc;
    longint s;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_pp0", pp[0], 0);
    chk("rst_pp8", pp[8], 0);

    // Basic: 3*5 everywhere
    for (int k = 0; k < 9; k++) begin a[k] = 3; w[k] = 5; end
    send(pack(a), pack(w));
    chk("e0_in_ready_low", in_ready, 0);
    chk("e0_busy_high", busy, 1);
    idle();
    drain();
    chk("basic_lane4", longint'($signed(pp[4])), 15);

    // Extremes
    a = '{-128, -128, 127, -1, 0, -128, -7, -7, -7};
    w = '{-128, 127, 127, -1, -128, 1, -2, 6, -85};
    send(pack(a), pack(w));
    idle();
    drain();
    chk("ext_lane0", longint'($signed(pp[0])), 16384);
    chk("ext_lane1", longint'($signed(pp[1])), -16256);
    chk("ext_lane8", longint'($signed(pp[8])), 595);

    // Back-to-back with in_valid held high
    send({$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom});
    first_acc = last_acc;
    send({$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom});
    chk("b2b_spacing", last_acc - first_acc, 5);
    idle();
    drain();

    // Input churn during RUN
    acc0 = n_acc;
    send({$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom});
    repeat (4) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      act_vec  = {$urandom, $urandom, $urandom};
      wgt_vec  = {$urandom, $urandom, $urandom};
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    chk("churn_accepts", n_acc - acc0, 1);

    // Reset at E2
    for (int k = 0; k < 9; k++) begin a[k] = 9; w[k] = 9; end
    send(pack(a), pack(w));
    idle();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_pp0", pp[0], 0);
    chk("midrst_pp5", pp[5], 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("postrst_in_ready", in_ready, 1);
    send({$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom});
    idle();
    drain();

    // Random regression
    for (int t = 0; t < 1000; t++) begin
      send({$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom});
      if ($urandom_range(0, 3) != 0) begin
        idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    idle();
    drain();

    // Adder-tree view: sum of the nine products
    for (int k = 0; k < 9; k++) begin a[k] = -128; w[k] = -128; end
    send(pack(a), pack(w));
    idle();
    drain();
    s = 0;
    for (int k = 0; k < 9; k++) s += longint'($signed(pp[k]));
    chk("tree_sum", s, 147456);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
